// File: rtl/iic_slave_mem_pkg.sv
// Shared definitions for the I2C byte-memory target: FSM state encoding and
// the default device address also used by the iic_control master.
package iic_slave_mem_pkg;

    localparam logic [6:0] IIC_DEV_ADDR = 7'b101_0110;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV,
        ST_DEV_ACK,
        ST_AH,
        ST_AH_ACK,
        ST_AL,
        ST_AL_ACK,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK
    } iic_state_t;

    // Each receive state hands over to its own ACK slot.
    function automatic iic_state_t ack_state(input iic_state_t rx);
        case (rx)
            ST_DEV:  return ST_DEV_ACK;
            ST_AH:   return ST_AH_ACK;
            ST_AL:   return ST_AL_ACK;
            default: return ST_WR_ACK;
        endcase
    endfunction

endpackage

// File: rtl/iic_slave_mem_if.sv
// Bus-side bundle of the I2C byte-memory target: SCL/SDA pins plus the
// commit-monitor outputs used by board self-tests.
interface iic_slave_mem_if #(
    parameter int MEM_AW = 8
);
    logic              iic_scl;
    logic              sda_in;
    logic              sda_oe;
    logic              wr_strb;
    logic [MEM_AW-1:0] wr_addr;
    logic [7:0]        wr_byte;
    logic              busy;

    modport slave (
        input  iic_scl, sda_in,
        output sda_oe, wr_strb, wr_addr, wr_byte, busy
    );

    modport master (
        output iic_scl, sda_in,
        input  sda_oe, wr_strb, wr_addr, wr_byte, busy
    );
endinterface

// File: rtl/iic_slave_mem_bus_sync.sv
// SCL/SDA synchronizer and bus-event detector (SCL edges, START, STOP);
// shared between the I2C target and the iic_control master.
module iic_slave_mem_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // Bits [1:0] are the two-flop synchronizer, bit [2] is the history flop.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // NOTE: reset to the idle-bus level (both lines high) so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign sda_s     = sda_q[1];
    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/iic_slave_mem.sv
// I2C target backed by a byte memory: byte/page write, random read and
// current-address read at DEVICE_ADDR, with a pointer that persists across transfers.
module iic_slave_mem
    import iic_slave_mem_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = IIC_DEV_ADDR,
    parameter int         ADDR_BYTES  = 2,
    parameter int         MEM_AW      = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rstn,
    iic_slave_mem_if.slave bus
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    iic_slave_mem_bus_sync u_sync (
        .clk       (sys_clk),
        .rst_n     (sys_rstn),
        .scl       (bus.iic_scl),
        .sda       (bus.sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    iic_state_t        state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              byte_done;
    logic              rw;
    logic [7:0]        addr_hi;
    logic [MEM_AW-1:0] ptr;
    logic              sda_oe_q;
    logic              busy_q;
    logic              wr_strb_q;
    logic [MEM_AW-1:0] wr_addr_q;
    logic [7:0]        wr_byte_q;

    logic [7:0]        mem [2**MEM_AW];
    logic [7:0]        rd_data;
    logic [7:0]        rx_byte;

    assign rd_data = mem[ptr];
    assign rx_byte = {shift[6:0], sda_s};

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            rw        <= 1'b0;
            addr_hi   <= '0;
            ptr       <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_strb_q <= 1'b0;
            wr_addr_q <= '0;
            wr_byte_q <= '0;
        end else begin
            wr_strb_q <= 1'b0;
            // STOP outranks START, and both outrank any SCL edge in the same sample.
            if (stop_det) begin
                state     <= ST_IDLE;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                byte_done <= 1'b0;
            end else if (start_det) begin
                state     <= ST_DEV;
                bit_cnt   <= '0;
                sda_oe_q  <= 1'b0;
                byte_done <= 1'b0;
            end else begin
                case (state)
                    ST_DEV, ST_AH, ST_AL, ST_WR: begin
                        if (scl_rise && !byte_done) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_done <= 1'b1;
                                case (state)
                                    ST_DEV: begin
                                        if (rx_byte[7:1] != DEVICE_ADDR) begin
                                            state     <= ST_IDLE;
                                            byte_done <= 1'b0;
                                        end
                                        rw <= rx_byte[0];
                                    end
                                    ST_AH:   addr_hi <= rx_byte;
                                    ST_AL:   ptr     <= MEM_AW'({addr_hi, rx_byte});
                                    default: begin
                                        wr_strb_q <= 1'b1;
                                        wr_addr_q <= ptr;
                                        wr_byte_q <= rx_byte;
                                        ptr       <= ptr + 1'b1;
                                    end
                                endcase
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe_q  <= 1'b1;
                            state     <= ack_state(state);
                            if (state == ST_DEV) busy_q <= 1'b1;
                        end
                    end

                    ST_DEV_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shift    <= rd_data;
                                sda_oe_q <= ~rd_data[7];
                                state    <= ST_RD;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state    <= (ADDR_BYTES == 2) ? ST_AH : ST_AL;
                            end
                        end
                    end

                    ST_AH_ACK, ST_AL_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= (state == ST_AH_ACK) ? ST_AL : ST_WR;
                        end
                    end

                    ST_RD: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                bit_cnt  <= '0;
                                state    <= ST_RD_ACK;
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                shift    <= {shift[6:0], 1'b0};
                                sda_oe_q <= ~shift[6];
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        // The slot is entered on a fall, so the next fall always follows an ACK.
                        if (scl_rise) begin
                            if (!sda_s) ptr   <= ptr + 1'b1;
                            else        state <= ST_IDLE;
                        end else if (scl_fall) begin
                            bit_cnt  <= '0;
                            shift    <= rd_data;
                            sda_oe_q <= ~rd_data[7];
                            state    <= ST_RD;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    // NOTE: the byte array has no reset; clearing every entry would prevent RAM inference.
    always_ff @(posedge sys_clk) begin
        if (wr_strb_q) mem[wr_addr_q] <= wr_byte_q;
    end

    assign bus.sda_oe  = sda_oe_q;
    assign bus.busy    = busy_q;
    assign bus.wr_strb = wr_strb_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_byte = wr_byte_q;

endmodule

// File: tb/tb_iic_slave_mem.sv
// Bench for iic_slave_mem: a bit-banged I2C master against a transaction-level
// memory model (array + pointer), with directed and randomized transfers.
module tb_iic_slave_mem;
    import iic_slave_mem_pkg::*;

    localparam int Q = 100;  // quarter SCL period in ns; SCL = 2.5 MHz vs 100 MHz sys_clk

    logic sys_clk  = 1'b0;
    logic sys_rstn = 1'b0;
    logic scl_m    = 1'b1;
    logic sda_m    = 1'b1;

    iic_slave_mem_if #(.MEM_AW(8)) bif ();
    assign bif.iic_scl = scl_m;
    assign bif.sda_in  = sda_m & ~bif.sda_oe;

    iic_slave_mem #(
        .DEVICE_ADDR (IIC_DEV_ADDR),
        .ADDR_BYTES  (2),
        .MEM_AW      (8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rstn (sys_rstn),
        .bus      (bif)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0]  model_mem [256];
    logic [7:0]  model_ptr;
    logic [15:0] strb_q [$];
    int          oe_cycles;
    int          n_vec;
    int          n_err;

    always @(negedge sys_clk) begin
        if (bif.wr_strb) strb_q.push_back({bif.wr_addr, bif.wr_byte});
        if (bif.sda_oe) oe_cycles++;
    end

    // ---------------- bus primitives ----------------
    task automatic bus_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; #(Q);
            scl_m = 1'b1; #(Q);
        end
        sda_m = 1'b0; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #(Q);
        scl_m = 1'b1; #(Q);
        sda_m = 1'b1; #(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    #(Q);
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        b = bif.sda_in; #(Q);
        scl_m = 1'b0; #(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_n);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(ack_n);
    endtask

    task automatic recv_byte(input logic ack_n, output logic [7:0] b);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            get_bit(bt);
            b[i] = bt;
        end
        put_bit(ack_n);
    endtask

    // ---------------- transactions with model update ----------------
    task automatic write_txn(input logic [15:0] waddr, input int n, input logic [7:0] d [8]);
        logic       ack_n;
        int         missing;
        logic [7:0] a;
        missing = 0;
        strb_q.delete();
        bus_start();
        send_byte({IIC_DEV_ADDR, 1'b0}, ack_n);
        if (ack_n) missing++;
        n_vec++;
        if (bif.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_dev_ack: got %b want 1", bif.busy);
        end
        send_byte(waddr[15:8], ack_n);
        if (ack_n) missing++;
        send_byte(waddr[7:0], ack_n);
        if (ack_n) missing++;
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], ack_n);
            if (ack_n) missing++;
        end
        bus_stop();

        for (int i = 0; i < n; i++) model_mem[waddr[7:0] + 8'(i)] = d[i];
        model_ptr = waddr[7:0] + 8'(n);

        n_vec++;
        if (missing != 0) begin
            n_err++;
            $display("FAIL write_acks addr=%h: %0d slots not ACKed, want 0", waddr, missing);
        end
        n_vec++;
        if (bif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_stop: got %b want 0", bif.busy);
        end
        n_vec++;
        if (strb_q.size() != n) begin
            n_err++;
            $display("FAIL wr_strb_count addr=%h: got %0d want %0d", waddr, strb_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                a = waddr[7:0] + 8'(i);
                n_vec++;
                if (strb_q[i] !== {a, d[i]}) begin
                    n_err++;
                    $display("FAIL wr_strb_%0d: got addr/data %h want %h", i, strb_q[i], {a, d[i]});
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            a = waddr[7:0] + 8'(i);
            n_vec++;
            if (dut.mem[a] !== model_mem[a]) begin
                n_err++;
                $display("FAIL mem[%h]: got %h want %h", a, dut.mem[a], model_mem[a]);
            end
        end
    endtask

    // random=1: dummy write of raddr then repeated START; random=0: current-address read.
    task automatic read_txn(input bit random, input logic [15:0] raddr, input int n);
        logic       ack_n;
        int         missing;
        logic [7:0] b;
        missing = 0;
        bus_start();
        if (random) begin
            send_byte({IIC_DEV_ADDR, 1'b0}, ack_n);
            if (ack_n) missing++;
            send_byte(raddr[15:8], ack_n);
            if (ack_n) missing++;
            send_byte(raddr[7:0], ack_n);
            if (ack_n) missing++;
            model_ptr = raddr[7:0];
            bus_start();
        end
        send_byte({IIC_DEV_ADDR, 1'b1}, ack_n);
        if (ack_n) missing++;
        n_vec++;
        if (missing != 0) begin
            n_err++;
            $display("FAIL read_acks addr=%h: %0d slots not ACKed, want 0", raddr, missing);
        end
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            n_vec++;
            if (b !== model_mem[model_ptr]) begin
                n_err++;
                $display("FAIL read_byte_%0d @%h: got %h want %h", i, model_ptr, b, model_mem[model_ptr]);
            end
            if (i < n - 1) model_ptr = model_ptr + 8'd1;
        end
        n_vec++;
        if (bif.sda_oe !== 1'b0) begin
            n_err++;
            $display("FAIL sda_after_nack: got %b want 0", bif.sda_oe);
        end
        bus_stop();
        n_vec++;
        if (bif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_read_stop: got %b want 0", bif.busy);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] v;
        sys_rstn = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            dut.mem[i]   = v;
            model_mem[i] = v;
        end
        model_ptr = 8'h00;
        repeat (4) @(posedge sys_clk);
        #1;
        n_vec++;
        if ({bif.sda_oe, bif.wr_strb, bif.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: sda_oe/wr_strb/busy got %b want 000", {bif.sda_oe, bif.wr_strb, bif.busy});
        end
        n_vec++;
        if ({bif.wr_addr, bif.wr_byte} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_wr_bus: got %h want 0000", {bif.wr_addr, bif.wr_byte});
        end
        sys_rstn = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        n_vec++;
        if (dut.state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state);
        end
    endtask

    task automatic test_byte_write();
        logic [7:0] d [8];
        d = '{8'hAB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_txn(16'hFA6A, 1, d);
    endtask

    task automatic test_random_read();
        read_txn(1'b1, 16'h006A, 1);
    endtask

    task automatic test_page_write_wrap();
        logic [7:0] d [8];
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        write_txn(16'h00FE, 4, d);
    endtask

    task automatic test_wrong_address();
        logic ack_n;
        int   diffs;
        strb_q.delete();
        oe_cycles = 0;
        bus_start();
        send_byte({7'h57, 1'b0}, ack_n);
        n_vec++;
        if (ack_n !== 1'b1) begin
            n_err++;
            $display("FAIL wrong_addr_ack: got %b want 1 (no ACK)", ack_n);
        end
        n_vec++;
        if (dut.state !== ST_IDLE) begin
            n_err++;
            $display("FAIL wrong_addr_state: got %0d want IDLE", dut.state);
        end
        send_byte(8'h5A, ack_n);
        send_byte(8'hC3, ack_n);
        bus_stop();
        n_vec++;
        if (oe_cycles != 0 || strb_q.size() != 0) begin
            n_err++;
            $display("FAIL wrong_addr_quiet: sda_oe cycles %0d strobes %0d want 0 0", oe_cycles, strb_q.size());
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (dut.mem[i] !== model_mem[i]) diffs++;
        n_vec++;
        if (diffs != 0) begin
            n_err++;
            $display("FAIL wrong_addr_mem: %0d bytes changed want 0", diffs);
        end
    endtask

    task automatic test_sequential_read();
        read_txn(1'b1, 16'h00FE, 3);
        read_txn(1'b0, 16'h0000, 2);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d [8];
        logic [15:0] a;
        int          n;
        for (int k = 0; k < 5; k++) begin
            a = 16'($urandom);
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < 8; i++) d[i] = 8'($urandom);
            write_txn(a, n, d);
            read_txn(1'b1, a, n);
            if ($urandom_range(0, 1) == 1) read_txn(1'b0, 16'h0000, int'($urandom_range(1, 3)));
        end
    endtask

    task automatic test_stop_and_reset();
        logic       ack_n;
        logic [7:0] keep;
        strb_q.delete();
        keep = model_mem[8'h34];
        bus_start();
        send_byte({IIC_DEV_ADDR, 1'b0}, ack_n);
        send_byte(8'h12, ack_n);
        send_byte(8'h34, ack_n);
        for (int i = 0; i < 5; i++) put_bit(1'($urandom));
        bus_stop();
        repeat (20) @(posedge sys_clk);
        #1;
        n_vec++;
        if (strb_q.size() != 0 || dut.mem[8'h34] !== keep) begin
            n_err++;
            $display("FAIL partial_byte: strobes %0d mem[34]=%h want 0 %h", strb_q.size(), dut.mem[8'h34], keep);
        end

        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(i == 0 ? 1'b0 : IIC_DEV_ADDR[i-1]);
        sda_m = 1'b1; #(Q);
        scl_m = 1'b1; #(Q);
        n_vec++;
        if (bif.sda_oe !== 1'b1) begin
            n_err++;
            $display("FAIL ack_before_reset: sda_oe got %b want 1", bif.sda_oe);
        end
        sys_rstn = 1'b0;
        #1;
        n_vec++;
        if (bif.sda_oe !== 1'b0 || bif.busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_release: sda_oe/busy got %b%b want 00", bif.sda_oe, bif.busy);
        end
        #(Q);
        scl_m = 1'b0; #(Q);
        bus_stop();
        sys_rstn = 1'b1;
        model_ptr = 8'h00;
        repeat (4) @(posedge sys_clk);
        read_txn(1'b0, 16'h0000, 1);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: run exceeded 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        oe_cycles = 0;
        test_reset();
        test_byte_write();
        test_random_read();
        test_page_write_wrap();
        test_wrong_address();
        test_sequential_read();
        test_back_to_back();
        test_stop_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
